// File: rtl/ip_mac_scheduler.sv
// Streaming inner-product scheduler: multiplies feature beats by ROM coefficients and accumulates one result per frame.
// Optional build macro IP_SATURATE_EN selects a saturating signed accumulator instead of a modulo-2^W one.
module ip_mac_scheduler #(
  parameter int N_FEAT = 41,
  parameter int W      = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         x_valid,
  output logic         x_ready,
  input  logic [W-1:0] x_data,
  input  logic         x_last,
  output logic [5:0]   theta_addr,
  input  logic [W-1:0] theta_data,
  output logic         h_valid,
  input  logic         h_ready,
  output logic [W-1:0] h_data,
  output logic         frame_err,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  localparam logic [5:0] LAST_IDX = 6'(N_FEAT - 1);

  state_t       state_r;
  logic [5:0]   cnt_r;
  logic [5:0]   idx_q_r;
  logic [W-1:0] x_q_r;
  logic [W-1:0] acc_r;
  logic         pend_r;
  logic         frame_err_r;

  logic         accept_s;
  logic         last_s;
  logic [W-1:0] prod_s;
  logic [W-1:0] term_s;
  logic [W-1:0] sum_s;

  // Signed add that clamps to the most positive/negative W-bit value on overflow.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] s;
    s = a + b;
    if ((a[W-1] == b[W-1]) && (s[W-1] != a[W-1])) begin
      sat_add = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sat_add = s;
    end
  endfunction

  assign accept_s   = x_valid && x_ready;
  assign last_s     = (cnt_r == LAST_IDX);
  assign x_ready    = (state_r == IDLE) || (state_r == RUN);
  assign theta_addr = x_ready ? cnt_r : 6'd0;
  assign h_valid    = (state_r == OUT);
  assign h_data     = acc_r;
  assign busy       = (state_r != IDLE);
  assign frame_err  = frame_err_r;
  assign prod_s     = x_q_r * theta_data;

  // Term selection: slot 0 is the bias, slot 1 is unused, the rest are products.
  always_comb begin
    term_s = '0;
    if (idx_q_r == 6'd0) begin
      term_s = theta_data;
    end else if (idx_q_r == 6'd1) begin
      term_s = '0;
    end else begin
      term_s = prod_s;
    end
  end

  // Accumulator adder, wrapping or saturating depending on the build.
  always_comb begin
    sum_s = '0;
`ifdef IP_SATURATE_EN
    sum_s = sat_add(acc_r, term_s);
`else
    sum_s = acc_r + term_s;
`endif
  end

  // Frame FSM, beat capture pipeline, accumulator and sticky protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 6'd0;
      idx_q_r     <= 6'd0;
      x_q_r       <= '0;
      acc_r       <= '0;
      pend_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      pend_r <= accept_s;
      if (accept_s) begin
        x_q_r   <= x_data;
        idx_q_r <= cnt_r;
        cnt_r   <= cnt_r + 6'd1;
        if (x_last != last_s) begin
          frame_err_r <= 1'b1;
        end
      end
      if (pend_r) begin
        acc_r <= sum_s;
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= last_s ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (accept_s && last_s) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          state_r <= OUT;
        end
        OUT: begin
          if (h_ready) begin
            state_r <= IDLE;
            cnt_r   <= 6'd0;
            acc_r   <= '0;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ip_mac_scheduler.md
IP_MAC_SCHEDULER -- requirements
Module: ip_mac_scheduler

Interface
REQ-001 Parameter N_FEAT, default 41: feature beats per frame, indices 0..N_FEAT-1.
REQ-002 Parameter W, default 32: data, coefficient and result width.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 x_valid  in  1  feature beat valid.
REQ-007 x_ready  out  1  scheduler accepts a beat when x_valid&&x_ready.
REQ-008 x_data  in  W  feature value for the current index.
REQ-009 x_last  in  1  marks the final beat of a frame; used only for error checking.
REQ-010 theta_addr  out  6  coefficient ROM address; equals the current beat index.
REQ-011 theta_data  in  W  ROM data for theta_addr, returned exactly 1 cycle after the address.
REQ-012 h_valid  out  1  result valid.
REQ-013 h_ready  in  1  result consumer ready.
REQ-014 h_data  out  W  accumulated inner product (hprime).
REQ-015 frame_err  out  1  sticky x_last protocol error.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, OUT.
REQ-018 IDLE: x_ready=1, cnt=0, acc=0; an accepted beat (index 0) sets cnt=1 and moves to RUN (N_FEAT>1).
REQ-019 RUN: x_ready=1; each accepted beat increments cnt; accepting index N_FEAT-1 moves to DRAIN; x_valid gaps hold state.
REQ-020 DRAIN: x_ready=0; the final pending term is added; next state OUT.
REQ-021 OUT: x_ready=0, h_valid=1, h_data=acc; h_valid&&h_ready returns to IDLE the next cycle.
REQ-022 theta_addr = cnt combinationally in IDLE and RUN, so the ROM word aligns with the captured beat one cycle later.
REQ-023 Pipeline: an accepted beat registers x_q, idx_q, pend=1; in the next cycle acc <= acc + term.
REQ-024 term = theta_data for idx_q==0 (bias; x ignored); 0 for idx_q==1 (unused slot); otherwise low W bits of x_q*theta_data, two's complement.
REQ-025 Latency: h_valid rises exactly 2 cycles after the cycle that accepts index N_FEAT-1.
REQ-026 h_data is held stable while h_valid&&!h_ready; no beat is accepted during DRAIN or OUT.
REQ-027 frame_err is set and held until rst when x_last=1 is accepted at index<N_FEAT-1, or x_last=0 is accepted at index N_FEAT-1; the frame still completes normally.

Reset
REQ-028 On rst in any state: state=IDLE, cnt=0, acc=0, pend=0, h_valid=0, h_data=0, frame_err=0, busy=0, theta_addr=0.
REQ-029 A frame interrupted by rst is discarded; the next accepted beat is index 0.
REQ-030 x_ready is 1 in the first cycle after rst deasserts.

Configuration
REQ-031 Macro IP_SATURATE_EN: when defined, each accumulate is a signed W-bit add saturating to 0x7FFFFFFF or 0x80000000 (saturation persists; later terms add to the clamped value).
REQ-032 Without IP_SATURATE_EN, accumulation wraps modulo 2^W and matches the combinational sum bit-exactly.

Verification
REQ-033 rst held 3 cycles -> h_valid=0, h_data=0, frame_err=0, busy=0, x_ready=1 after release.
REQ-034 theta0=5, theta2..40=1, all x=1, continuous beats -> h_data=44, h_valid 2 cycles after last accept.
REQ-035 x1=0xFFFF, theta1=7, others 0, theta0=0 -> h_data=0; x_last on index 20 -> frame_err=1, result still produced.
REQ-036 h_ready low 5 cycles in OUT -> h_data stable and x_ready=0 throughout; accept on h_ready -> IDLE next cycle.
REQ-037 theta2=theta3=0x40000000, x2=x3=1, others 0 -> h_data=0x7FFFFFFF with IP_SATURATE_EN, 0x80000000 without.
REQ-038 rst after 20 beats, then the REQ-034 frame -> h_data=44, no residue.
